// File: rtl/jt03_mix_pkg.sv
// jt03_mix_pkg: shared widths, FSM encoding and saturation helper for the FM/SSG mixer
package jt03_mix_pkg;
   typedef enum logic [1:0] {IDLE, MUL_FM, MUL_PSG, SUM} state_t;
   localparam int GAIN_FRAC = 4;
   localparam int FM_W      = 16;
   localparam int PSG_EXT_W = 15;
   localparam int AC_W      = 17;
   localparam int SUM_W     = 22;
   localparam logic signed [SUM_W-1:0] SAT_MAX = 22'sd32767;
   localparam logic signed [SUM_W-1:0] SAT_MIN = -22'sd32768;

   function automatic logic signed [FM_W-1:0] sat(input logic signed [SUM_W-1:0] s);
      return s > SAT_MAX ? 16'sh7fff : s < SAT_MIN ? 16'sh8000 : s[FM_W-1:0];
   endfunction
endpackage

// File: rtl/jt03_mix_dc.sv
// jt03_mix_dc: SSG leaky-integrator DC estimator; ac is the level minus the current estimate
module jt03_mix_dc
   import jt03_mix_pkg::*;
#(
   parameter int DC_SHIFT = 8,
   parameter bit DC_EN    = 1'b1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 upd,
   input  logic [PSG_EXT_W-1:0] psg_ext,
   output logic [PSG_EXT_W-1:0] dc,
   output logic [AC_W-1:0]      ac
);
   localparam int ACC_W = PSG_EXT_W + DC_SHIFT;

   logic [ACC_W-1:0] dc_acc;

   assign dc = dc_acc[ACC_W-1:DC_SHIFT];

   // both operands are non-negative, so the 17-bit difference is a valid signed value
   always_comb ac = DC_EN ? {2'b0, psg_ext} - {2'b0, dc} : {2'b0, psg_ext};

   always_ff @(posedge clk)
      if (rst) dc_acc <= '0;
      else if (clk_en && upd) dc_acc <= dc_acc + ACC_W'(psg_ext) - ACC_W'(dc);
endmodule

// File: rtl/jt03_mix.sv
// jt03_mix: captures FM and SSG levels per sample, applies gains through one shared
// multiplier, removes SSG DC, then sums and saturates to a signed 16-bit output
module jt03_mix
   import jt03_mix_pkg::*;
#(
   parameter int DC_SHIFT = 8,
   parameter bit DC_EN    = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic signed [15:0] fm_snd,
   input  logic              fm_strobe,
   input  logic [9:0]        psg_snd,
   input  logic [7:0]        fm_gain,
   input  logic [7:0]        psg_gain,
   output logic signed [15:0] snd,
   output logic              sample,
   output logic              overrun
);
   state_t state, nxt;
   logic signed [FM_W-1:0]  fm_r;
   logic [PSG_EXT_W-1:0]    psg_ext;
   logic [7:0]              gf, gp;
   logic signed [AC_W-1:0]  ac_r;
   logic [AC_W-1:0]         ac;
   logic [PSG_EXT_W-1:0]    dc;
   logic signed [19:0]      prod_fm;
   logic signed [20:0]      prod_psg;
   logic signed [AC_W-1:0]  mul_a;
   logic signed [8:0]       mul_b;
   logic signed [AC_W+8:0]  mul_p;
   logic signed [SUM_W-1:0] sum;
   logic                    accept;
   logic                    mul_unused;
   logic                    dc_unused;

   jt03_mix_dc #(.DC_SHIFT(DC_SHIFT), .DC_EN(DC_EN)) u_dc (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .upd     (state == MUL_FM),
      .psg_ext (psg_ext),
      .dc      (dc),
      .ac      (ac)
   );

   always_comb begin
      nxt    = state == IDLE    ? (fm_strobe ? MUL_FM : IDLE) :
               state == MUL_FM  ? MUL_PSG :
               state == MUL_PSG ? SUM : IDLE;
      accept = state == IDLE && fm_strobe;
   end

   // one multiplier: FM operands while in MUL_FM, SSG operands otherwise
   always_comb begin
      mul_a = state == MUL_FM ? {{(AC_W-FM_W){fm_r[FM_W-1]}}, fm_r} : ac_r;
      mul_b = {1'b0, state == MUL_FM ? gf : gp};
      mul_p = mul_a * mul_b;
      sum   = {{(SUM_W-20){prod_fm[19]}}, prod_fm} + {{(SUM_W-21){prod_psg[20]}}, prod_psg};
   end

   assign mul_unused = ^{mul_p[AC_W+8], mul_p[GAIN_FRAC-1:0]};
   assign dc_unused  = ^dc;

   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         fm_r     <= '0;
         psg_ext  <= '0;
         gf       <= '0;
         gp       <= '0;
         ac_r     <= '0;
         prod_fm  <= '0;
         prod_psg <= '0;
         snd      <= '0;
         sample   <= 1'b0;
         overrun  <= 1'b0;
      end else if (clk_en) begin
         state  <= nxt;
         sample <= state == SUM;
         if (fm_strobe && state != IDLE) overrun <= 1'b1;
         if (accept) begin
            fm_r    <= fm_snd;
            psg_ext <= {psg_snd, 5'b0};
            gf      <= fm_gain;
            gp      <= psg_gain;
         end
         if (state == MUL_FM) begin
            prod_fm <= mul_p[GAIN_FRAC +: 20];
            ac_r    <= ac;
         end
         if (state == MUL_PSG) prod_psg <= mul_p[GAIN_FRAC +: 21];
         if (state == SUM) snd <= sat(sum);
      end
endmodule

// File: tb/tb_jt03_mix.sv
// tb_jt03_mix: scoreboard bench; expected samples queued at strobe time, popped by a monitor
module tb_jt03_mix;
   logic clk = 0, rst = 1, clk_en = 1, fm_strobe = 0;
   logic signed [15:0] fm_snd = 0;
   logic [9:0] psg_snd = 0;
   logic [7:0] fm_gain = 0, psg_gain = 0;
   logic signed [15:0] snd, snd2;
   logic sample, sample2, overrun, overrun2;
   int checks = 0, errors = 0;
   longint dc_acc_m = 0;

   typedef struct { int e_dc; int e_nodc; } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   jt03_mix u_dut (.clk(clk), .rst(rst), .clk_en(clk_en), .fm_snd(fm_snd), .fm_strobe(fm_strobe),
      .psg_snd(psg_snd), .fm_gain(fm_gain), .psg_gain(psg_gain), .snd(snd), .sample(sample), .overrun(overrun));
   jt03_mix #(.DC_EN(1'b0)) u_nodc (.clk(clk), .rst(rst), .clk_en(clk_en), .fm_snd(fm_snd), .fm_strobe(fm_strobe),
      .psg_snd(psg_snd), .fm_gain(fm_gain), .psg_gain(psg_gain), .snd(snd2), .sample(sample2), .overrun(overrun2));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clamp(input int s);
      return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
   endfunction

   // reference: floor-scaled gains, leaky integrator with time constant 256 samples
   function automatic exp_t model(input int fm, input int psg, input int gf, input int gp);
      exp_t r;
      int ext, dc, ac;
      ext = psg * 32;
      dc  = int'(dc_acc_m / 256);
      ac  = ext - dc;
      dc_acc_m += ac;
      r.e_dc   = clamp(((fm * gf) >>> 4) + ((ac * gp) >>> 4));
      r.e_nodc = clamp(((fm * gf) >>> 4) + ((ext * gp) >>> 4));
      return r;
   endfunction

   // monitor: every enabled edge that leaves sample high is a new output
   always @(posedge clk) begin
      logic en;
      exp_t e;
      en = clk_en && !rst;
      #1;
      if (en && (sample || sample2)) begin
         chk("sample_pair", int'(sample2), int'(sample));
         if (q.size() == 0) chk("unexpected_sample", 1, 0);
         else begin
            e = q.pop_front();
            chk("snd_dc", int'(snd), e.e_dc);
            chk("snd_nodc", int'(snd2), e.e_nodc);
         end
      end
   end

   task automatic do_reset();
      rst = 1; clk_en = 1; fm_strobe = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      dc_acc_m = 0;
   endtask

   task automatic run_seq(input int fm, input int psg, input int gf, input int gp, input int gap, input bit dbl);
      fm_snd = 16'(fm); psg_snd = 10'(psg); fm_gain = 8'(gf); psg_gain = 8'(gp);
      fm_strobe = 1; clk_en = 1;
      q.push_back(model(fm, psg, gf, gp));
      @(negedge clk);
      fm_strobe = dbl;
      fm_snd = 16'($urandom); psg_snd = 10'($urandom); fm_gain = 8'($urandom); psg_gain = 8'($urandom);
      @(negedge clk);
      fm_strobe = 0;
      if (gap > 0) begin
         clk_en = 0;
         repeat (gap) @(negedge clk);
         clk_en = 1;
      end
      @(negedge clk);
      @(negedge clk);
      if (gap > 0) chk("sample_e3", int'(sample), 1);
      if (gap > 0) begin
         clk_en = 0;
         repeat (gap) begin
            @(negedge clk);
            chk("sample_hold", int'(sample), 1);
         end
         clk_en = 1;
      end
      @(negedge clk);
      if (gap > 0 || dbl) chk("sample_e4", int'(sample), 0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      chk("rst_snd", int'(snd), 0);
      chk("rst_sample", int'(sample), 0);
      chk("rst_overrun", int'(overrun), 0);
      run_seq(1000, 0, 16, 16, 1, 1'b0);
      chk("no_overrun", int'(overrun), 0);
      run_seq(32767, 0, 32, 16, 0, 1'b0);
      chk("sat_hi", int'(snd), 32767);
      run_seq(-32768, 0, 32, 16, 0, 1'b0);
      chk("sat_lo", int'(snd), -32768);
      run_seq(-12345, 1023, 0, 0, 0, 1'b0);
      chk("gain_zero", int'(snd), 0);
      for (int i = 0; i < 60; i++)
         run_seq(int'($signed(16'($urandom))), int'($urandom_range(0, 1023)),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)), 0, 1'b0);
      run_seq(int'($signed(16'($urandom))), 700, 200, 90, 5, 1'b0);
      do_reset();
      run_seq(0, 512, 16, 16, 0, 1'b0);
      chk("dc_first", int'(snd), 16384);
      for (int i = 0; i < 4096; i++) run_seq(0, 512, 16, 16, 0, 1'b0);
      chk("dc_settled", int'(snd < 64 && snd > -64), 1);
      chk("nodc_hold", int'(snd2), 16384);
      run_seq(5000, 300, 16, 16, 0, 1'b1);
      chk("overrun_set", int'(overrun), 1);
      run_seq(-700, 100, 48, 20, 0, 1'b0);
      chk("overrun_sticky", int'(overrun), 1);
      fm_snd = 16'sd1234; psg_snd = 10'd77; fm_gain = 8'h10; psg_gain = 8'h10; fm_strobe = 1;
      @(negedge clk);
      fm_strobe = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      dc_acc_m = 0;
      chk("midrst_snd", int'(snd), 0);
      chk("midrst_sample", int'(sample), 0);
      chk("midrst_overrun", int'(overrun), 0);
      repeat (4) @(negedge clk);
      chk("midrst_no_pulse", int'(sample), 0);
      run_seq(-2000, 400, 24, 40, 0, 1'b0);
      repeat (5) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
